// File: rtl/job_sequencer_pkg.sv
// Shared types for the job sequencer.
//   seq_state_e : sequencer FSM state encoding
package job_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        START,
        RUN,
        REPORT
    } seq_state_e;

endpackage

// File: rtl/job_sequencer_sat_counter.sv
// Clearable up-counter that saturates at a terminal count.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear to zero
//   en    : count enable (holds once count reaches TC)
//   count : current count
//   tc    : count == TC
module sat_counter #(
    parameter int unsigned    W  = 8,
    parameter logic [W-1:0]   TC = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != TC)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC);

endmodule

// File: rtl/job_sequencer.sv
// Run controller for the processor core: accepts a tagged job, pulses the
// core's init then req, measures RUN cycles until ack (or timeout) and
// returns a tagged result record.
//   clk, init                 : clock, synchronous active-high reset
//   job_valid/job_ready/job_tag : job request channel
//   cpu_init, cpu_req, cpu_ack  : core control / completion
//   result_valid/result_ready   : result channel
//   result_tag/cycles/timeout   : result record
//
// state    | meaning
// IDLE     | ready for a job
// CORE_RST | core init held high for INIT_CYCLES cycles
// START    | one-cycle core req pulse, cycle counter cleared
// RUN      | counting cycles until ack or TIMEOUT
// REPORT   | result record held until consumed
module job_sequencer
    import job_sequencer_pkg::*;
#(
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned TIMEOUT     = 65535,
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             init,
    input  logic             job_valid,
    input  logic [TAG_W-1:0] job_tag,
    output logic             job_ready,
    output logic             cpu_init,
    output logic             cpu_req,
    input  logic             cpu_ack,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [TAG_W-1:0] result_tag,
    output logic [CYC_W-1:0] result_cycles,
    output logic             result_timeout
);

    localparam int unsigned      INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_TC  = INIT_W'(INIT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  RUN_TC   = CYC_W'(TIMEOUT);

    seq_state_e         state, next_state;
    logic [TAG_W-1:0]   tag_q;
    logic [INIT_W-1:0]  init_count_unused;
    logic               init_tc;
    logic [CYC_W-1:0]   run_count;
    logic               run_tc;
    logic               accept;
    logic               run_done;

    // job_ready is registered and already 0 during reset, so it gates acceptance
    assign accept   = (state == IDLE) && job_valid && job_ready;
    assign run_done = (state == RUN) && (cpu_ack || run_tc);

    sat_counter #(.W(INIT_W), .TC(INIT_TC)) u_init_cnt (
        .clk   (clk),
        .rst   (init),
        .clr   (accept),
        .en    (state == CORE_RST),
        .count (init_count_unused),
        .tc    (init_tc)
    );

    sat_counter #(.W(CYC_W), .TC(RUN_TC)) u_run_cnt (
        .clk   (clk),
        .rst   (init),
        .clr   (state == START),
        .en    ((state == RUN) && !cpu_ack),
        .count (run_count),
        .tc    (run_tc)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept)                       next_state = CORE_RST;
            CORE_RST: if (init_tc)                      next_state = START;
            START:                                      next_state = RUN;
            RUN:      if (cpu_ack || run_tc)            next_state = REPORT;
            REPORT:   if (result_valid && result_ready) next_state = IDLE;
            default:                                    next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they describe without any input-to-output combinational path.
    always_ff @(posedge clk) begin
        if (init) begin
            state          <= IDLE;
            tag_q          <= '0;
            job_ready      <= 1'b0;
            cpu_init       <= 1'b0;
            cpu_req        <= 1'b0;
            result_valid   <= 1'b0;
            result_tag     <= '0;
            result_cycles  <= '0;
            result_timeout <= 1'b0;
        end else begin
            state        <= next_state;
            job_ready    <= (next_state == IDLE);
            cpu_init     <= (next_state == CORE_RST);
            cpu_req      <= (next_state == START);
            result_valid <= (next_state == REPORT);
            if (accept) begin
                tag_q <= job_tag;
            end
            if (run_done) begin
                // ack wins over a coincident timeout
                result_tag     <= tag_q;
                result_cycles  <= run_count;
                result_timeout <= !cpu_ack;
            end
        end
    end

endmodule

// File: tb/tb_job_sequencer.sv
module tb_job_sequencer;

    localparam int CYC_W       = 16;
    localparam int TAG_W       = 4;
    localparam int INIT_CYCLES = 2;
    localparam int TIMEOUT     = 20;

    logic             clk = 1'b0;
    logic             init = 1'b1;
    logic             job_valid = 1'b0;
    logic [TAG_W-1:0] job_tag = '0;
    logic             job_ready;
    logic             cpu_init;
    logic             cpu_req;
    logic             cpu_ack = 1'b0;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [TAG_W-1:0] result_tag;
    logic [CYC_W-1:0] result_cycles;
    logic             result_timeout;

    int n_cmp = 0;
    int n_err = 0;

    job_sequencer #(
        .CYC_W       (CYC_W),
        .TIMEOUT     (TIMEOUT),
        .INIT_CYCLES (INIT_CYCLES),
        .TAG_W       (TAG_W)
    ) dut (
        .clk            (clk),
        .init           (init),
        .job_valid      (job_valid),
        .job_tag        (job_tag),
        .job_ready      (job_ready),
        .cpu_init       (cpu_init),
        .cpu_req        (cpu_req),
        .cpu_ack        (cpu_ack),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_tag     (result_tag),
        .result_cycles  (result_cycles),
        .result_timeout (result_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer a job; returns at the negedge after the handshake edge.
    task automatic handshake(input logic [TAG_W-1:0] tag);
        job_valid = 1'b1;
        job_tag   = tag;
        check("job_ready_idle", 32'(job_ready), 32'd1);
        nclk();
        job_valid = 1'b0;
        job_tag   = '0;
    endtask

    // CORE_RST (2 cycles) then START (1 cycle); ends with the DUT in RUN.
    task automatic core_seq();
        check("init_c1", 32'({cpu_init, cpu_req, job_ready}), 32'b100);
        nclk();
        check("init_c2", 32'({cpu_init, cpu_req}), 32'b10);
        nclk();
        check("req_c1", 32'({cpu_init, cpu_req}), 32'b01);
        nclk();
        check("run_quiet", 32'({cpu_init, cpu_req, result_valid}), 32'b000);
    endtask

    // ack_at < 0 means never ack.
    task automatic run_phase(input int ack_at);
        int edges;
        edges = 0;
        while (!result_valid && edges < 60) begin
            cpu_ack = (edges == ack_at);
            nclk();
            edges++;
        end
        cpu_ack = 1'b0;
        if (!result_valid) check("run_bound", 32'd0, 32'd1);
    endtask

    task automatic collect(input logic [TAG_W-1:0] tag, input int cyc, input logic to);
        check("res_valid",   32'(result_valid),   32'd1);
        check("res_tag",     32'(result_tag),     32'(tag));
        check("res_cycles",  32'(result_cycles),  32'(cyc));
        check("res_timeout", 32'(result_timeout), 32'(to));
        check("ready_busy",  32'(job_ready),      32'd0);
        result_ready = 1'b1;
        nclk();
        result_ready = 1'b0;
        check("post_res", 32'({result_valid, job_ready}), 32'b01);
    endtask

    initial begin
        // reset and idle
        for (int i = 0; i < 3; i++) begin
            nclk();
            check("rst_ctl", 32'({job_ready, cpu_init, cpu_req, result_valid, result_timeout}), 32'd0);
            check("rst_rec", 32'({result_tag, result_cycles}), 32'd0);
        end
        init = 1'b0;
        nclk();
        check("ready_after_rst", 32'(job_ready), 32'd1);

        // nominal
        handshake(4'hA);
        core_seq();
        run_phase(7);
        collect(4'hA, 7, 1'b0);

        // immediate ack
        handshake(4'h2);
        core_seq();
        run_phase(0);
        collect(4'h2, 0, 1'b0);

        // timeout, then recovery
        handshake(4'h7);
        core_seq();
        run_phase(-1);
        collect(4'h7, 20, 1'b1);
        handshake(4'h8);
        core_seq();
        run_phase(3);
        collect(4'h8, 3, 1'b0);

        // back-pressure with a second job waiting
        handshake(4'h5);
        core_seq();
        run_phase(2);
        job_valid = 1'b1;
        job_tag   = 4'h9;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 32'({result_valid, job_ready, cpu_init}), 32'b100);
            check("bp_rec",  32'({result_tag, result_cycles, result_timeout}), {11'd0, 4'h5, 16'd2, 1'b0});
            nclk();
        end
        result_ready = 1'b1;
        nclk();
        result_ready = 1'b0;
        check("bp_after_h", 32'({job_ready, cpu_init, result_valid}), 32'b100);
        nclk();
        job_valid = 1'b0;
        job_tag   = '0;
        core_seq();
        run_phase(1);
        collect(4'h9, 1, 1'b0);

        // reset mid-run at count 5
        handshake(4'h3);
        core_seq();
        for (int i = 0; i < 5; i++) nclk();
        init = 1'b1;
        nclk();
        check("midrst_ctl", 32'({job_ready, cpu_init, cpu_req, result_valid}), 32'd0);
        cpu_ack = 1'b1;
        nclk();
        check("midrst_rec", 32'({result_valid, result_tag, result_cycles}), 32'd0);
        init    = 1'b0;
        cpu_ack = 1'b0;
        nclk();
        check("midrst_idle", 32'({job_ready, result_valid, cpu_init}), 32'b100);
        handshake(4'hC);
        core_seq();
        run_phase(4);
        collect(4'hC, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
